apb_master_param: RTL and testbench
===================================

APB_MASTER_PARAM -- requirements
Module: apb_master_param

Interface
REQ-001 Parameter ADDR_W, default 8: address width (range 4..32).
REQ-002 Parameter DATA_W, default 8: data width (8, 16 or 32).
REQ-003 Parameter NSLV, default 4: number of slaves, one psel bit per slave (range 1..8).
REQ-004 Parameter TIMEOUT_CYC, default 16: ACCESS-cycle limit before abort (range 2..255).
REQ-005 pclk  in  1  sole clock; all state updates on its rising edge.
REQ-006 prst  in  1  synchronous active-high reset.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  command accepted this cycle when high together with cmd_valid.
REQ-009 cmd_write  in  1  1 = write, 0 = read.
REQ-010 cmd_addr  in  ADDR_W  target address.
REQ-011 cmd_wdata  in  DATA_W  write data.
REQ-012 cmd_strb  in  DATA_W/8  write byte strobes.
REQ-013 rsp_valid  out  1  one-cycle completion pulse; no backpressure.
REQ-014 rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
REQ-015 rsp_err  out  1  slave error, decode error or timeout.
REQ-016 psel  out  NSLV  one-hot slave select.
REQ-017 penable, pwrite  out  1 each  APB enable and direction.
REQ-018 paddr  out  ADDR_W; pwdata  out  DATA_W; pstrb  out  DATA_W/8.
REQ-019 pready, pslverr  in  1 each; prdata  in  DATA_W (externally muxed slave response).

Function
REQ-020 FSM SHALL have three states: IDLE, SETUP, ACCESS.
REQ-021 cmd_ready = (IDLE & !prst) | (ACCESS & pready & no timeout).
REQ-022 On accept, command fields SHALL be registered; slave index = cmd_addr[ADDR_W-1:ADDR_W-3].
REQ-023 Index >= NSLV: no bus cycle, FSM stays/returns IDLE; rsp_valid=1, rsp_err=1, rsp_rdata=0 next cycle.
REQ-024 Valid index: the next cycle is SETUP (psel[idx]=1, penable=0), then ACCESS (psel[idx]=1, penable=1).
REQ-025 paddr, pwrite, pwdata and pstrb SHALL be stable from SETUP through the last ACCESS cycle.
REQ-026 Reads SHALL drive pstrb=0 and pwdata=0.
REQ-027 ACCESS holds while pready=0.
REQ-028 On pready=1: rsp_valid=1 next cycle; rsp_err=pslverr; rsp_rdata=prdata on read without error, otherwise 0.
REQ-029 On pready=1 with a command accepted in the same cycle, next state SHALL be SETUP (back-to-back, penable drops for one cycle); otherwise IDLE.
REQ-030 Zero-wait latency SHALL be 3 cycles from accept edge to rsp_valid; each wait state adds 1.
REQ-031 psel and penable SHALL be 0 in IDLE; at most one psel bit high at any time.

Reset
REQ-032 prst high at an edge SHALL force IDLE, abort any transfer, and zero psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err and the timeout counter.
REQ-033 A transfer interrupted by reset SHALL produce no rsp_valid.

Configuration
REQ-034 With APB_MASTER_TIMEOUT_EN defined, the ACCESS cycle count SHALL be tracked.
REQ-035 When TIMEOUT_CYC ACCESS cycles elapse with pready=0, the FSM SHALL deassert psel/penable and go to IDLE, with rsp_valid=1, rsp_err=1, rsp_rdata=0 next cycle.
REQ-036 Without APB_MASTER_TIMEOUT_EN, no counter logic SHALL exist and ACCESS waits indefinitely.

Structure
REQ-037 Package apb_master_pkg SHALL hold the state enum (IDLE/SETUP/ACCESS) and the slave-index field width constant (3).
REQ-038 Sub-module apb_wdog (load, count, expire) SHALL implement the timeout and is instantiated only under APB_MASTER_TIMEOUT_EN.

Verification
REQ-039 Write 0x5A to addr 0x21, strb 1, pready=1 -> psel=4'b0010 one cycle penable=0 then one cycle penable=1; rsp_valid 3 cycles after accept, rsp_err=0.
REQ-040 Read addr 0x40, 2 wait states, prdata=0xC3 -> ACCESS lasts 3 cycles, pstrb=0, rsp_rdata=0xC3 5 cycles after accept.
REQ-041 Read addr 0xE0 with NSLV=4 -> psel stays 0; rsp_valid, rsp_err=1, rsp_rdata=0 next cycle.
REQ-042 Two back-to-back writes with cmd_valid held -> second SETUP immediately after first ACCESS; psel held, penable 1,0,1.
REQ-043 pslverr=1 with pready=1 -> rsp_err=1; with APB_MASTER_TIMEOUT_EN and pready stuck 0 -> abort after 16 ACCESS cycles, rsp_err=1.
REQ-044 prst asserted during ACCESS -> next cycle all outputs 0, no rsp_valid, cmd_ready=1 after prst drops.

Source files
------------

// File: rtl/apb_master_pkg.sv
// -----------------------------------------------------------------------------
// apb_master_pkg
// Shared types and constants for the parameterised APB master.
//   state_t : bus FSM states (IDLE, SETUP, ACCESS)
//   IDX_W   : width of the slave-index field taken from the top address bits
// -----------------------------------------------------------------------------
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int IDX_W = 3;

endpackage

// File: rtl/apb_master_wdog.sv
// -----------------------------------------------------------------------------
// apb_wdog
// ACCESS-phase watchdog for the APB master. It only exists in the design when
// APB_MASTER_TIMEOUT_EN is defined.
// Ports:
//   pclk   : clock
//   prst   : synchronous active-high reset
//   load   : restart the count (asserted while the FSM is in SETUP)
//   count  : one more ACCESS cycle without pready
//   expire : high during the LIMIT-th consecutive ACCESS cycle without pready
// -----------------------------------------------------------------------------
module apb_wdog #(
    parameter int LIMIT = 16
) (
    input  logic pclk,
    input  logic prst,
    input  logic load,
    input  logic count,
    output logic expire
);

    logic [7:0] cnt;

    // cnt holds the number of waited ACCESS cycles already completed, so the
    // current cycle is number cnt+1 and expiry fires when that reaches LIMIT.
    assign expire = count && (cnt == 8'(LIMIT - 1));

    always_ff @(posedge pclk) begin
        if (prst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (count && !expire) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/apb_master_param.sv
// -----------------------------------------------------------------------------
// apb_master_param
// Command-to-APB bridge: accepts one command at a time, decodes the slave from
// the top three address bits, runs a SETUP/ACCESS cycle and returns a one-cycle
// response pulse. Optional ACCESS timeout when APB_MASTER_TIMEOUT_EN is defined.
// Ports:
//   pclk, prst                    : clock, synchronous active-high reset
//   cmd_valid/cmd_ready           : command handshake
//   cmd_write/addr/wdata/strb     : command fields
//   rsp_valid/rsp_rdata/rsp_err   : completion pulse, read data, error flag
//   psel/penable/pwrite           : APB control (psel one-hot per slave)
//   paddr/pwdata/pstrb            : APB address and write payload
//   pready/pslverr/prdata         : muxed slave response
// -----------------------------------------------------------------------------
module apb_master_param
    import apb_master_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int NSLV        = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                pclk,
    input  logic                prst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [NSLV-1:0]     psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    input  logic                pready,
    input  logic                pslverr,
    input  logic [DATA_W-1:0]   prdata
);

    state_t           state;
    state_t           state_n;
    logic [IDX_W-1:0] cmd_idx;
    logic [IDX_W-1:0] idx_q;
    logic             cmd_bad;
    logic             accept;
    logic             done;
    logic             timeout;
    logic             derr;
    logic             err_pend;

    assign cmd_idx   = cmd_addr[ADDR_W-1 -: IDX_W];
    assign cmd_bad   = (int'(cmd_idx) >= NSLV);
    assign cmd_ready = ((state == IDLE) && !prst) ||
                       ((state == ACCESS) && pready && !timeout);
    assign accept    = cmd_valid && cmd_ready;
    assign done      = (state == ACCESS) && pready;
    assign derr      = accept && cmd_bad;

`ifdef APB_MASTER_TIMEOUT_EN
    apb_wdog #(
        .LIMIT(TIMEOUT_CYC)
    ) u_wdog (
        .pclk  (pclk),
        .prst  (prst),
        .load  (state == SETUP),
        .count ((state == ACCESS) && !pready),
        .expire(timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (prst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept && !cmd_bad) begin
                    state_n = SETUP;
                end
            end
            SETUP: begin
                state_n = ACCESS;
            end
            ACCESS: begin
                if (timeout) begin
                    state_n = IDLE;
                end else if (pready) begin
                    state_n = (accept && !cmd_bad) ? SETUP : IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Command fields are captured on every accept. A back-to-back accept lands
    // on the final ACCESS edge, so the old values stay stable through ACCESS.
    // Reads carry zero write data and strobes.
    always_ff @(posedge pclk) begin
        if (prst) begin
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
            pstrb  <= '0;
            idx_q  <= '0;
        end else if (accept) begin
            paddr  <= cmd_addr;
            pwrite <= cmd_write;
            pwdata <= cmd_write ? cmd_wdata : '0;
            pstrb  <= cmd_write ? cmd_strb : '0;
            idx_q  <= cmd_idx;
        end
    end

    // A decode error accepted on the same edge as a bus completion, or while
    // an earlier decode error is still waiting, is held in err_pend and
    // reported one cycle later, so no response is ever lost.
    always_ff @(posedge pclk) begin
        if (prst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            err_pend  <= 1'b0;
        end else begin
            err_pend <= derr && (done || timeout || err_pend);
            if (done || timeout) begin
                rsp_valid <= 1'b1;
                rsp_err   <= timeout || pslverr;
                rsp_rdata <= (done && !pwrite && !pslverr) ? prdata : '0;
            end else if (derr || err_pend) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end else begin
                rsp_valid <= 1'b0;
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
            end
        end
    end

    always_comb begin
        psel = '0;
        if (state != IDLE) begin
            for (int i = 0; i < NSLV; i++) begin
                if (int'(idx_q) == i) begin
                    psel[i] = 1'b1;
                end
            end
        end
    end

    assign penable = (state == ACCESS);

endmodule

// File: tb/tb_apb_master_param.sv
// -----------------------------------------------------------------------------
// tb_apb_master_param
// Self-checking bench for apb_master_param (default parameters). Expected
// responses are queued when a command is accepted and compared when rsp_valid
// pulses. Covers APB_MASTER_TIMEOUT_EN when that macro is defined.
// -----------------------------------------------------------------------------
module tb_apb_master_param;

    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 8;
    localparam int NSLV        = 4;
    localparam int TIMEOUT_CYC = 16;
    localparam int HIST        = 2048;

    logic              pclk = 1'b0;
    logic              prst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic [0:0]        cmd_strb = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [NSLV-1:0]   psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [0:0]        pstrb;
    logic              pready = 1'b0;
    logic              pslverr = 1'b0;
    logic [DATA_W-1:0] prdata = '0;

    apb_master_param #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSLV(NSLV), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .pclk(pclk), .prst(prst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic       err;
        logic [7:0] rdata;
        int         when;
    } exp_t;

    exp_t       sb[$];
    exp_t       got;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         viol = 0;
    int         wait_cfg = 0;
    logic       serr_cfg = 1'b0;
    logic [7:0] rdata_cfg = 8'h00;
    logic [3:0] psel_hist [0:HIST-1];
    logic       pen_hist  [0:HIST-1];
    logic [17:0] setup_snap;

    always @(posedge pclk) cyc <= cyc + 1;

    // Per-cycle monitor: history, protocol rules and the response scoreboard.
    always @(negedge pclk) begin
        if (cyc < HIST) begin
            psel_hist[cyc] = psel;
            pen_hist[cyc]  = penable;
        end
        if (!prst) begin
            if ($countones(psel) > 1 || (penable && psel == '0)) viol++;
            if (psel != '0 && !penable) setup_snap = {paddr, pwrite, pwdata, pstrb};
            if (penable && {paddr, pwrite, pwdata, pstrb} !== setup_snap) viol++;
        end
        if (rsp_valid === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("[TB] FAIL rsp_unexpected: rsp_valid=1 at cycle %0d, required none", cyc);
            end else begin
                got = sb.pop_front();
                if (rsp_err !== got.err || rsp_rdata !== got.rdata || cyc != got.when) begin
                    n_bad++;
                    $display("[TB] FAIL rsp: got err=%0b rdata=%h cycle=%0d, required err=%0b rdata=%h cycle=%0d",
                             rsp_err, rsp_rdata, cyc, got.err, got.rdata, got.when);
                end
            end
        end
    end

    // Slave model: pready rises after wait_cfg wait states of ACCESS.
    initial begin
        int acc_cnt;
        acc_cnt = 0;
        forever begin
            @(negedge pclk);
            if (psel != '0 && penable) begin
                if (acc_cnt >= wait_cfg) begin
                    pready  = 1'b1;
                    pslverr = serr_cfg;
                    prdata  = rdata_cfg;
                end else begin
                    pready  = 1'b0;
                    pslverr = 1'b0;
                    prdata  = 8'hEE;
                end
                acc_cnt++;
            end else begin
                pready  = 1'b0;
                pslverr = 1'b0;
                prdata  = 8'h00;
                acc_cnt = 0;
            end
        end
    end

    // Drive one command, wait for acceptance and queue its expected response.
    task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                         input logic st, input bit hold, input bit expect_rsp,
                         output int acc);
        exp_t e;
        int   k;
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_strb  = st;
        #1;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 200) begin
            @(negedge pclk);
            #1;
            k++;
        end
        acc = cyc;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, k);
            cmd_valid = 1'b0;
            return;
        end
        if (expect_rsp) begin
            if (int'(addr[7:5]) >= NSLV) begin
                e.err = 1'b1; e.rdata = 8'h00; e.when = acc + 1;
            end else begin
`ifdef APB_MASTER_TIMEOUT_EN
                if (wait_cfg >= TIMEOUT_CYC) begin
                    e.err = 1'b1; e.rdata = 8'h00; e.when = acc + 2 + TIMEOUT_CYC;
                end else
`endif
                begin
                    e.err   = serr_cfg;
                    e.rdata = (!wr && !serr_cfg) ? rdata_cfg : 8'h00;
                    e.when  = acc + 3 + wait_cfg;
                end
            end
            sb.push_back(e);
        end
        @(posedge pclk);
        if (!hold) begin
            #1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge pclk);
            #2;
            k++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL drain: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
        @(negedge pclk);
        #2;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        #1;
        n_cmp++;
        if ({psel, penable, pwrite, paddr, pwdata, pstrb} !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_bus: got %h, required 0", {psel, penable, pwrite, paddr, pwdata, pstrb});
        end
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_rsp: got %h, required 0", {rsp_valid, rsp_err, rsp_rdata});
        end
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_ready_in_reset: got %b, required 0", cmd_ready);
        end
        prst = 1'b0;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL reset_ready_after: got %b, required 1", cmd_ready);
        end
    endtask

    task automatic test_write_basic();
        int a;
        wait_cfg = 0; serr_cfg = 1'b0; rdata_cfg = 8'h77;
        issue(1'b1, 8'h21, 8'h5A, 1'b1, 1'b0, 1'b1, a);
        wait_idle();
        n_cmp++;
        if ({psel_hist[a+1], pen_hist[a+1], psel_hist[a+2], pen_hist[a+2], psel_hist[a+3], pen_hist[a+3]}
            !== {4'b0010, 1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL write_phases: got psel/pen %b%b %b%b %b%b, required 0010/0 0010/1 0000/0",
                     psel_hist[a+1], pen_hist[a+1], psel_hist[a+2], pen_hist[a+2], psel_hist[a+3], pen_hist[a+3]);
        end
        n_cmp++;
        if ({paddr, pwrite, pwdata, pstrb} !== {8'h21, 1'b1, 8'h5A, 1'b1}) begin
            n_bad++;
            $display("[TB] FAIL write_fields: got addr=%h wr=%b wd=%h strb=%b, required 21 1 5a 1",
                     paddr, pwrite, pwdata, pstrb);
        end
    endtask

    task automatic test_read_wait();
        int a;
        int n;
        wait_cfg = 2; serr_cfg = 1'b0; rdata_cfg = 8'hC3;
        issue(1'b0, 8'h40, 8'hFF, 1'b1, 1'b0, 1'b1, a);
        wait_idle();
        n = 0;
        for (int i = a + 1; i <= a + 7; i++) if (pen_hist[i] === 1'b1) n++;
        n_cmp++;
        if (n != 3 || psel_hist[a+1] !== 4'b0100) begin
            n_bad++;
            $display("[TB] FAIL read_access: got %0d ACCESS cycles psel=%b, required 3 and 0100", n, psel_hist[a+1]);
        end
        n_cmp++;
        if ({pwrite, pwdata, pstrb} !== '0) begin
            n_bad++;
            $display("[TB] FAIL read_payload: got wr=%b wd=%h strb=%b, required 0 00 0", pwrite, pwdata, pstrb);
        end
        wait_cfg = 0;
    endtask

    task automatic test_decode_err();
        int a;
        issue(1'b0, 8'hE0, 8'h00, 1'b0, 1'b0, 1'b1, a);
        wait_idle();
        n_cmp++;
        if ({psel_hist[a+1], pen_hist[a+1], psel_hist[a+2], pen_hist[a+2]} !== '0) begin
            n_bad++;
            $display("[TB] FAIL decode_nobus: got psel %b/%b, required 0000/0000", psel_hist[a+1], psel_hist[a+2]);
        end
    endtask

    task automatic test_back_to_back();
        int a1;
        int a2;
        wait_cfg = 0; serr_cfg = 1'b0;
        issue(1'b1, 8'h22, 8'h11, 1'b1, 1'b1, 1'b1, a1);
        issue(1'b1, 8'h23, 8'h22, 1'b1, 1'b0, 1'b1, a2);
        wait_idle();
        n_cmp++;
        if (a2 != a1 + 2) begin
            n_bad++;
            $display("[TB] FAIL b2b_accept: got second accept at +%0d, required +2", a2 - a1);
        end
        n_cmp++;
        if ({pen_hist[a1+1], pen_hist[a1+2], pen_hist[a1+3], pen_hist[a1+4], pen_hist[a1+5]} !== 5'b01010) begin
            n_bad++;
            $display("[TB] FAIL b2b_penable: got %b%b%b%b%b, required 01010",
                     pen_hist[a1+1], pen_hist[a1+2], pen_hist[a1+3], pen_hist[a1+4], pen_hist[a1+5]);
        end
        n_cmp++;
        if ({psel_hist[a1+1], psel_hist[a1+2], psel_hist[a1+3], psel_hist[a1+4]} !== {4{4'b0010}}) begin
            n_bad++;
            $display("[TB] FAIL b2b_psel: got %b %b %b %b, required 0010 held",
                     psel_hist[a1+1], psel_hist[a1+2], psel_hist[a1+3], psel_hist[a1+4]);
        end
    endtask

    task automatic test_slverr();
        int a;
        wait_cfg = 0; serr_cfg = 1'b1; rdata_cfg = 8'hC3;
        issue(1'b0, 8'h61, 8'h00, 1'b0, 1'b0, 1'b1, a);
        wait_idle();
        issue(1'b1, 8'h05, 8'h99, 1'b1, 1'b0, 1'b1, a);
        wait_idle();
        serr_cfg = 1'b0;
    endtask

    task automatic test_long_access();
        int a;
        int n;
        int req;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cfg = 1000;
        req = TIMEOUT_CYC;
`else
        wait_cfg = 20;
        req = 21;
`endif
        rdata_cfg = 8'h3C;
        issue(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, a);
        wait_idle();
        repeat (25) @(negedge pclk);
        n = 0;
        for (int i = a + 1; i <= a + 40; i++) if (pen_hist[i] === 1'b1) n++;
        n_cmp++;
        if (n != req) begin
            n_bad++;
            $display("[TB] FAIL long_access: got %0d ACCESS cycles, required %0d", n, req);
        end
        wait_cfg = 0;
    endtask

    task automatic test_reset_mid();
        int a;
        wait_cfg = 5;
        issue(1'b0, 8'h60, 8'h00, 1'b0, 1'b0, 1'b0, a);
        @(negedge pclk);
        @(negedge pclk);
        #1;
        n_cmp++;
        if (penable !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL rstmid_access: got penable=%b, required 1", penable);
        end
        prst = 1'b1;
        @(negedge pclk);
        #1;
        n_cmp++;
        if ({psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_err, rsp_rdata} !== '0) begin
            n_bad++;
            $display("[TB] FAIL rstmid_outputs: got psel=%b pen=%b addr=%h rsp=%b, required all 0",
                     psel, penable, paddr, rsp_valid);
        end
        prst = 1'b0;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL rstmid_ready: got %b, required 1", cmd_ready);
        end
        repeat (10) @(negedge pclk);
        wait_cfg = 0;
    endtask

    task automatic test_random();
        int         a;
        logic [7:0] addr;
        logic [3:0] exp_sel;
        for (int t = 0; t < 12; t++) begin
            wait_cfg  = $urandom_range(0, 3);
            serr_cfg  = ($urandom_range(0, 3) == 0);
            rdata_cfg = 8'($urandom);
            addr      = 8'($urandom);
            issue(1'($urandom), addr, 8'($urandom), 1'($urandom), 1'b0, 1'b1, a);
            wait_idle();
            exp_sel = (int'(addr[7:5]) >= NSLV) ? 4'b0000 : 4'(1 << addr[7:5]);
            n_cmp++;
            if (psel_hist[a+1] !== exp_sel) begin
                n_bad++;
                $display("[TB] FAIL random_psel: addr=%h got %b, required %b", addr, psel_hist[a+1], exp_sel);
            end
        end
        serr_cfg = 1'b0;
        wait_cfg = 0;
    endtask

    task automatic test_final();
        n_cmp++;
        if (viol != 0) begin
            n_bad++;
            $display("[TB] FAIL protocol: got %0d violations, required 0", viol);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL leftover: got %0d queued, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_wait();
        test_decode_err();
        test_back_to_back();
        test_slverr();
        test_long_access();
        test_reset_mid();
        test_random();
        test_final();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
